fir_parallel_l3_pipeline: RTL and testbench
===========================================

FIR_PARALLEL_L3_PIPELINE -- requirements
Module: fir_parallel_L3_pipeline

Interface
REQ-001 SHALL have parameter N, default 100, giving the number of filter taps.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port valid, input, 1 bit: input-block qualifier.
REQ-005 SHALL have port coeffs, input, unpacked array [N] of signed 32-bit values: coeffs[k] is tap h(k); held static during operation.
REQ-006 SHALL have ports x1, x2, x3, input, signed 32-bit each: samples x(3m), x(3m+1), x(3m+2) of block m.
REQ-007 SHALL have ports y1, y2, y3, output, signed 32-bit each, registered: outputs y(3m), y(3m+1), y(3m+2) of block m.

Function
REQ-008 SHALL compute y(n) = sum over k=0..N-1 of h(k)*x(n-k), with x(n<0) = 0 and pre-reset history = 0.
REQ-009 SHALL use signed 32x32 products and accumulation of at least 64 bits, and SHALL output the low 32 bits (two's-complement wrap, no saturation).
REQ-010 SHALL process 3 samples per clock using the polyphase decomposition with M = ceil(N/3), H_j(k) = h(3k+j), and taps beyond N-1 treated as zero.
REQ-011 SHALL combine lanes as: y1 = H0*x1 + D(H1*x3 + H2*x2); y2 = H0*x2 + H1*x1 + D(H2*x3); y3 = H0*x3 + H1*x2 + H2*x1. D is a one-block delay; each Hj* term is a length-M sub-filter running on one lane's block-rate history.
REQ-012 SHALL capture x1..x3 into the lane delay lines on a rising edge only when valid=1; when valid=0, histories hold.
REQ-013 SHALL be pipelined in two register stages: stage 1 holds the 9 sub-filter results, stage 2 holds the lane sums driving y1..y3.
REQ-014 SHALL have latency 2: for a block sampled at edge e, y1..y3 show its results after edge e+2 and hold them for one full cycle.
REQ-015 SHALL advance the pipeline stages every cycle regardless of valid; after valid falls, the last valid block still emerges and outputs then hold that value.
REQ-016 SHALL support any N >= 1; N not divisible by 3 is handled by zero padding with no extra latency.

Reset
REQ-017 SHALL, while rst=0, asynchronously clear all delay lines, stage registers and y1..y3 to 0.
REQ-018 SHALL, when rst is asserted mid-stream, discard all history; after release, output matches a filter starting from zero state.

Structure
REQ-019 SHALL take shared constants from package fir_pkg: DATA_W=32, ACC_W=64, L=3, and a ceil-divide function for M.
REQ-020 SHALL use one sub-module, fir_subfilter (parameter M): one lane input, one coefficient phase, returns the combinational wide sum; instantiate it 9 times.
REQ-021 SHALL fit in 120-400 lines of RTL.

Verification
REQ-022 Impulse: N=100, h(k)=k+1; block (1,0,0) then zero blocks, valid=1 -> output blocks (1,2,3), (4,5,6), ..., (97,98,99), (100,0,0), then zeros. First block appears 2 edges after sampling.
REQ-023 Random stream: 90 samples (30 blocks) with random coeffs, compared against the REQ-008 golden model -> 90/90 matches, with outputs checked two cycles after each input block.
REQ-024 Valid gap: stream 5 blocks, drop valid 3 cycles, resume -> output equals the filter of the concatenated valid blocks only; held values are repeated during the gap.
REQ-025 Wrap: all taps 0x7FFFFFFF, all x = 0x7FFFFFFF -> y equals the low 32 bits of the exact 64-bit sum.
REQ-026 Reset mid-operation: assert rst after 10 blocks -> y1..y3 = 0 immediately (asynchronous); after release, restart output equals a fresh-filter response.
REQ-027 N=4 (non-multiple of 3), impulse -> output blocks (h0,h1,h2), (h3,0,0), then zeros.

Source files
------------

// File: rtl/fir_pkg.sv
// Shared widths and helpers for the three-lane polyphase FIR.
package fir_pkg;
  localparam int DATA_W = 32;
  localparam int ACC_W  = 64;
  localparam int L      = 3;

  function automatic int ceil_div(input int a, input int b);
    return (a + b - 1) / b;
  endfunction
endpackage

// File: rtl/fir_subfilter.sv
// One polyphase branch: combinational dot product of a lane history with one coefficient phase.
module fir_subfilter
  import fir_pkg::*;
#(
  parameter int M = 1
) (
  input  logic signed [DATA_W-1:0] taps [M],
  input  logic signed [DATA_W-1:0] h    [M],
  output logic signed [ACC_W-1:0]  sum
);

  logic signed [ACC_W-1:0] prod;

  always_comb begin
    sum  = '0;
    prod = '0;
    for (int k = 0; k < M; k++) begin
      prod = ACC_W'(taps[k]) * ACC_W'(h[k]);
      sum  = sum + prod;
    end
  end

endmodule

// File: rtl/fir_parallel_l3_pipeline.sv
// Three-samples-per-clock FIR built from nine polyphase sub-filters, with a
// sub-filter register stage followed by a lane-sum register stage.
module fir_parallel_l3_pipeline
  import fir_pkg::*;
#(
  parameter int N = 100
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     valid,
  input  logic signed [DATA_W-1:0] coeffs [N],
  input  logic signed [DATA_W-1:0] x1,
  input  logic signed [DATA_W-1:0] x2,
  input  logic signed [DATA_W-1:0] x3,
  output logic signed [DATA_W-1:0] y1,
  output logic signed [DATA_W-1:0] y2,
  output logic signed [DATA_W-1:0] y3
);

  localparam int M = ceil_div(N, L);

  logic signed [DATA_W-1:0] lane_x  [L];
  logic signed [DATA_W-1:0] phase_h [L][M];
  // One extra entry per lane supplies the one-block-delayed branches.
  logic signed [DATA_W-1:0] hist_q  [L][M+1];
  logic signed [DATA_W-1:0] hist_d  [L][M+1];
  logic signed [ACC_W-1:0]  sub_d   [L][L];
  logic signed [ACC_W-1:0]  sub_q   [L][L];
  logic signed [ACC_W-1:0]  lane_sum [L];
  logic signed [DATA_W-1:0] y_d     [L];
  logic signed [DATA_W-1:0] y_q     [L];

  assign lane_x[0] = x1;
  assign lane_x[1] = x2;
  assign lane_x[2] = x3;

  genvar gi, gj, gk;

  generate
    for (gi = 0; gi < L; gi++) begin : g_phase
      for (gk = 0; gk < M; gk++) begin : g_tap
        if (L * gk + gi < N) begin : g_real
          assign phase_h[gi][gk] = coeffs[L * gk + gi];
        end else begin : g_pad
          assign phase_h[gi][gk] = '0;
        end
      end
    end
  endgenerate

  always_comb begin
    hist_d = hist_q;
    if (valid) begin
      for (int l = 0; l < L; l++) begin
        hist_d[l][0] = lane_x[l];
        for (int k = 1; k <= M; k++) begin
          hist_d[l][k] = hist_q[l][k-1];
        end
      end
    end
  end

  // Output o with phase j reads lane (o-j) mod L; a negative difference
  // wraps into the previous block, hence the one-entry history offset.
  generate
    for (gi = 0; gi < L; gi++) begin : g_out
      for (gj = 0; gj < L; gj++) begin : g_br
        localparam int SRC = (gi - gj + L) % L;
        localparam int DLY = (gi < gj) ? 1 : 0;
        logic signed [DATA_W-1:0] taps [M];
        for (gk = 0; gk < M; gk++) begin : g_sel
          assign taps[gk] = hist_q[SRC][gk + DLY];
        end
        fir_subfilter #(.M(M)) u_sub (
          .taps (taps),
          .h    (phase_h[gj]),
          .sum  (sub_d[gi][gj])
        );
      end
    end
  endgenerate

  always_comb begin
    for (int o = 0; o < L; o++) begin
      lane_sum[o] = sub_q[o][0] + sub_q[o][1] + sub_q[o][2];
      y_d[o]      = lane_sum[o][DATA_W-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int l = 0; l < L; l++) begin
        for (int k = 0; k <= M; k++) begin
          hist_q[l][k] <= '0;
        end
        for (int j = 0; j < L; j++) begin
          sub_q[l][j] <= '0;
        end
        y_q[l] <= '0;
      end
    end else begin
      hist_q <= hist_d;
      sub_q  <= sub_d;
      y_q    <= y_d;
    end
  end

  assign y1 = y_q[0];
  assign y2 = y_q[1];
  assign y3 = y_q[2];

endmodule

// File: tb/tb_fir_parallel_l3_pipeline.sv
// Bench: two DUTs (N=100, N=4) on one sample stream, checked against a direct-convolution model.
module tb_fir_parallel_l3_pipeline;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic valid = 1'b0;
  logic signed [31:0] x1 = '0, x2 = '0, x3 = '0;
  logic signed [31:0] c100 [100];
  logic signed [31:0] c4 [4];
  logic signed [31:0] y1, y2, y3, z1, z2, z3;

  int passed = 0;
  int total = 0;

  int xs[$];
  int cnt0 = 0, cnt1 = 0, cnt2 = 0;

  always #5 clk = ~clk;

  fir_parallel_l3_pipeline #(.N(100)) dut (
    .clk(clk), .rst(rst), .valid(valid), .coeffs(c100),
    .x1(x1), .x2(x2), .x3(x3), .y1(y1), .y2(y2), .y3(y3)
  );

  fir_parallel_l3_pipeline #(.N(4)) dut4 (
    .clk(clk), .rst(rst), .valid(valid), .coeffs(c4),
    .x1(x1), .x2(x2), .x3(x3), .y1(z1), .y2(z2), .y3(z3)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
  endtask

  // y(n) = sum h(k) x(n-k) over the samples accepted since the last reset.
  function automatic logic [31:0] golden(input int n, input bit four);
    longint acc = 0;
    longint h;
    int nt = four ? 4 : 100;
    for (int k = 0; k < nt; k++) begin
      if (n - k >= 0) begin
        h = four ? longint'(c4[k]) : longint'(c100[k]);
        acc += h * longint'(xs[n-k]);
      end
    end
    return acc[31:0];
  endfunction

  // Model state: accepted samples plus the accepted-block count two edges back.
  always @(posedge clk) begin
    if (!rst) begin
      xs.delete();
      cnt0 = 0; cnt1 = 0; cnt2 = 0;
    end else begin
      if (valid) begin
        xs.push_back(int'(x1));
        xs.push_back(int'(x2));
        xs.push_back(int'(x3));
      end
      cnt2 = cnt1;
      cnt1 = cnt0;
      cnt0 = xs.size() / 3;
    end
  end

  always @(negedge clk) begin
    logic [31:0] ya [3];
    logic [31:0] za [3];
    logic [31:0] ea, eb;
    ya[0] = y1; ya[1] = y2; ya[2] = y3;
    za[0] = z1; za[1] = z2; za[2] = z3;
    for (int j = 0; j < 3; j++) begin
      if (!rst || cnt2 == 0) begin
        ea = '0; eb = '0;
      end else begin
        ea = golden(3 * (cnt2 - 1) + j, 1'b0);
        eb = golden(3 * (cnt2 - 1) + j, 1'b1);
      end
      chk($sformatf("model_n100_y%0d", j + 1), ya[j], ea);
      chk($sformatf("model_n4_y%0d", j + 1), za[j], eb);
    end
  end

  task automatic step(input logic v, input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
    valid = v; x1 = a; x2 = b; x3 = c;
    @(posedge clk);
    #1;
  endtask

  task automatic enter_reset();
    valid = 1'b0;
    rst = 1'b0;
    #1;
  endtask

  task automatic leave_reset();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  task automatic rand_block();
    step(1'b1, $urandom, $urandom, $urandom);
  endtask

  task automatic rand_coeffs();
    for (int k = 0; k < 100; k++) c100[k] = $urandom;
    for (int k = 0; k < 4; k++) c4[k] = $urandom;
  endtask

  initial begin
    logic [31:0] e1, e2, e3, f1, f2, f3;
    int b;
    for (int k = 0; k < 100; k++) c100[k] = k + 1;
    c4[0] = 5; c4[1] = -7; c4[2] = 11; c4[3] = 13;

    repeat (2) @(posedge clk);
    #1;
    chk("reset_y1", y1, 0); chk("reset_y2", y2, 0); chk("reset_y3", y3, 0);
    chk("reset_z1", z1, 0); chk("reset_z2", z2, 0); chk("reset_z3", z3, 0);
    rst = 1'b1;

    // Impulse: hand-computed output blocks.
    step(1'b1, 1, 0, 0);
    for (int i = 1; i <= 40; i++) begin
      step(1'b1, 0, 0, 0);
      if (i >= 2) begin
        b = i - 2;
        if (b < 33) begin
          e1 = 3 * b + 1; e2 = 3 * b + 2; e3 = 3 * b + 3;
        end else if (b == 33) begin
          e1 = 100; e2 = 0; e3 = 0;
        end else begin
          e1 = 0; e2 = 0; e3 = 0;
        end
        if (b == 0) begin
          f1 = 5; f2 = -7; f3 = 11;
        end else if (b == 1) begin
          f1 = 13; f2 = 0; f3 = 0;
        end else begin
          f1 = 0; f2 = 0; f3 = 0;
        end
        chk("impulse_y1", y1, e1); chk("impulse_y2", y2, e2); chk("impulse_y3", y3, e3);
        chk("impulse_z1", z1, f1); chk("impulse_z2", z2, f2); chk("impulse_z3", z3, f3);
      end
    end

    // Random stream of 30 blocks.
    enter_reset();
    rand_coeffs();
    leave_reset();
    for (int i = 0; i < 30; i++) rand_block();
    repeat (3) step(1'b0, 0, 0, 0);

    // Valid gap: invalid samples must be ignored, outputs held.
    enter_reset();
    rand_coeffs();
    leave_reset();
    for (int i = 0; i < 5; i++) rand_block();
    for (int i = 0; i < 3; i++) step(1'b0, $urandom, $urandom, $urandom);
    for (int i = 0; i < 5; i++) rand_block();
    repeat (4) step(1'b0, $urandom, $urandom, $urandom);

    // Wrap: steady state low 32 bits of N*(2^31-1)^2.
    enter_reset();
    for (int k = 0; k < 100; k++) c100[k] = 32'h7FFF_FFFF;
    for (int k = 0; k < 4; k++) c4[k] = 32'h7FFF_FFFF;
    leave_reset();
    for (int i = 0; i < 40; i++) step(1'b1, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h7FFF_FFFF);
    chk("wrap_y1", y1, 100); chk("wrap_y2", y2, 100); chk("wrap_y3", y3, 100);
    chk("wrap_z1", z1, 4); chk("wrap_z2", z2, 4); chk("wrap_z3", z3, 4);

    // Mid-stream reset: outputs clear without waiting for a clock edge.
    enter_reset();
    rand_coeffs();
    leave_reset();
    for (int i = 0; i < 10; i++) rand_block();
    rst = 1'b0;
    #1;
    chk("midrst_y1", y1, 0); chk("midrst_y2", y2, 0); chk("midrst_y3", y3, 0);
    chk("midrst_z1", z1, 0); chk("midrst_z2", z2, 0); chk("midrst_z3", z3, 0);
    valid = 1'b1;
    leave_reset();
    step(1'b1, 1, 0, 0);
    for (int i = 0; i < 14; i++) step(1'b1, 0, 0, 0);
    for (int i = 0; i < 6; i++) rand_block();
    repeat (3) step(1'b0, 0, 0, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
